mips_fetch_unit: RTL
====================

# mips_fetch_unit

Instruction-fetch front end of the MIPS pipeline. Owns the program counter and drives the word address into the combinational instruction memory. Captures the returned instruction word into the IF/ID pipeline register for the decode stage. Handles stalls, branch/jump redirects with bubble insertion, a halt word, out-of-range fetch detection, and a fetch counter.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset (word aligned).
- `IMEM_WORDS`, 1024: instruction memory depth in words. The legal fetch range is 0 .. IMEM_WORDS*4-4.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetch.
- `clk` in 1: the single clock. Every register updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out 32: byte address presented to the instruction memory. It equals the PC register.
- `imem_instr` in 32: instruction word returned combinationally, in the same cycle, for `imem_addr`.
- `stall` in 1: hazard unit request to hold the PC and the IF/ID register.
- `branch_taken` in 1: branch resolved taken by EX.
- `branch_target` in 32: byte target for the branch.
- `jump` in 1: J/JAL resolved by ID.
- `jump_index` in 26: the instr_index field of the jump.
- `if_id_instr` out 32: fetched instruction. It is 32'h0 (NOP) when invalid.
- `if_id_pc4` out 32: fetch address + 4 of `if_id_instr`.
- `if_id_valid` out 1: the IF/ID register holds a real instruction.
- `halted` out 1: the fetch unit is in HALT.
- `addr_err` out 1: sticky flag for an out-of-range or misaligned fetch.
- `fetch_count` out 32: number of valid instructions loaded into IF/ID. It saturates.

## Operation
- States:
  - BOOT: one cycle after reset release. The PC holds RESET_PC, IF/ID is not loaded, and `stall` is ignored. The next state is always RUN.
  - RUN: normal fetch.
  - HALT: the PC is frozen, IF/ID is loaded with a bubble every cycle, and `halted`=1.
- Redirect target:
  - The branch target is `branch_target` with bits [1:0] forced to 0.
  - The jump target is {if_id_pc4[31:28], jump_index, 2'b00}.
  - If both `branch_taken` and `jump` are asserted, the branch wins because it comes from the older instruction.
- RUN, per cycle, in priority order:
  1. Redirect (`branch_taken` or `jump`): PC <= target and IF/ID <= bubble (instr 0, pc4 0, valid 0). This applies even when `stall`=1.
  2. `stall`: PC and IF/ID hold. The counter holds.
  3. Otherwise:
     - IF/ID <= {imem_instr, PC+4, valid 1}, PC <= PC+4, and `fetch_count` increments.
     - If `imem_instr`==HALT_WORD, the halt word is still loaded as valid and the next state is HALT. The PC holds at the halt word's address and does not take PC+4.
- Out-of-range fetch: if PC >= IMEM_WORDS*4 in RUN, nothing is loaded and IF/ID <= bubble. `addr_err` is set and the next state is HALT. A redirect in the same cycle takes priority: it redirects and no error is raised.
- Misaligned branch target (bits [1:0] != 0): `addr_err` is set, the target is still applied with bits forced to 0, and the state stays RUN.
- HALT exits only on a redirect, which is treated as an older instruction overriding a speculative halt. PC <= target, IF/ID <= bubble, next state RUN. `addr_err` stays set.
- `fetch_count` stays at 32'hFFFF_FFFF once it reaches it.
- PC+4 wraps modulo 2^32. Arithmetic is 32-bit unsigned.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - PC = RESET_PC, state = BOOT.
  - `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0.
  - `halted`=0, `addr_err`=0, `fetch_count`=0.
  - `imem_addr`=RESET_PC.
- Reset asserted mid-operation clears everything immediately, with no clock needed.
- Fetch latency is one cycle: the word at `imem_addr` in cycle N appears on `if_id_*` in cycle N+1.
- Redirect penalty:
  - The redirect is sampled in cycle N. Cycle N+1 shows a bubble and `imem_addr`=target.
  - The target instruction is valid in cycle N+2.
- `halted` is registered and rises in the cycle after the halt word is captured, together with the first HALT bubble.
- All outputs are registered except `imem_addr`, which is a direct copy of the PC register.

## Structure
- A shared package `mips_pkg` holds:
  - the NOP constant 32'h0;
  - the fetch state enum {BOOT, RUN, HALT};
  - the jump-target field widths (index 26, upper PC 4).
- One sub-module, `if_id_reg`, is natural. It is the IF/ID pipeline register with load, hold and bubble controls.
- The PC, the state machine and the counter stay in `mips_fetch_unit`.

## Test plan
- Reset then free run, with imem words 0..3 = A,B,C,D:
  - Cycle 1 after release is BOOT with valid=0.
  - Then `if_id_instr` = A,B,C,D on consecutive cycles, with `if_id_pc4`=4,8,12,16.
  - `fetch_count`=4.
- `stall` held 3 cycles at PC=8: `imem_addr` stays 8, the IF/ID contents and the count are unchanged, and the sequence resumes with the word at 8.
- `branch_taken`=1 with target 32'h40 together with `stall`=1:
  - The next cycle has valid=0 and `imem_addr`=32'h40.
  - The word at 32'h40 is valid one cycle later.
- Simultaneous `jump` (index 26'h10) and `branch_taken` (target 32'h20): the PC becomes 32'h20, not 32'h40.
- HALT_WORD at address 12:
  - It is loaded with valid=1, `halted`=1 on the following cycle, and the PC is frozen at 12 with bubbles.
  - A later branch to 0 clears `halted` and fetch resumes from 0.
- With IMEM_WORDS=4, run to PC=16: `addr_err`=1, `halted`=1, and `fetch_count`=4. Assert `rst_n`=0 mid-halt: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS instruction-fetch front end:
//   - NOP encoding used for pipeline bubbles
//   - fetch state machine encoding
//   - J/JAL target field widths and a helper that assembles the jump target
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int JUMP_INDEX_W = 26;
    localparam int PC_UPPER_W   = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // J/JAL target: upper PC bits of the delay-slot address, the 26-bit
    // instr_index, and two zero bits for word alignment.
    function automatic logic [31:0] jump_target(
        input logic [PC_UPPER_W-1:0]   pc_upper,
        input logic [JUMP_INDEX_W-1:0] index
    );
        return {pc_upper, index, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register between fetch and decode.
//   Controls (priority order): i_bubble > i_load > hold.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bubble          : load NOP / pc4 0 / valid 0
//   load            : capture instr / pc4 with valid 1
//   instr, pc4      : incoming fetched word and its fetch address + 4
//   if_id_instr     : registered instruction (NOP when invalid)
//   if_id_pc4       : registered fetch address + 4 (0 when invalid)
//   if_id_valid     : register holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble,
    input  logic        load,
    input  logic [31:0] instr,
    input  logic [31:0] pc4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (bubble) begin
            r_instr <= NOP;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_instr <= instr;
            r_pc4   <= pc4;
            r_valid <= 1'b1;
        end
    end

    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;

endmodule

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
// Instruction-fetch front end: owns the PC, drives the combinational
// instruction memory, captures returned words into IF/ID, and handles stall,
// branch/jump redirect with bubble insertion, halt word, fetch-range errors
// and a saturating fetch counter.
//   Parameters: RESET_PC, IMEM_WORDS, HALT_WORD
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_addr   (out 32)    : byte fetch address (copy of PC register)
//   imem_instr  (in 32)     : word returned for imem_addr, same cycle
//   stall       (in)        : hold PC and IF/ID
//   branch_taken/target     : EX-resolved branch redirect (wins over jump)
//   jump/jump_index         : ID-resolved J/JAL redirect
//   if_id_instr/pc4/valid   : IF/ID pipeline register contents
//   halted      (out)       : fetch unit sits in HALT
//   addr_err    (out)       : sticky out-of-range / misaligned fetch flag
//   fetch_count (out 32)    : saturating count of valid IF/ID loads
// -----------------------------------------------------------------------------
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [31:0]             imem_addr,
    input  logic [31:0]             imem_instr,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [31:0]             branch_target,
    input  logic                    jump,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    output logic [31:0]             if_id_instr,
    output logic [31:0]             if_id_pc4,
    output logic                    if_id_valid,
    output logic                    halted,
    output logic                    addr_err,
    output logic [31:0]             fetch_count
);

    // One bit wider than the PC so a 4 GiB memory does not wrap to zero.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_count;
    logic         r_halted;
    logic         r_addr_err;

    logic         w_redirect;
    logic         w_branch_misaligned;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_fetch_err;
    logic         w_is_halt;

    fetch_state_t w_state_next;
    logic [31:0]  w_pc_next;
    logic         w_load;
    logic         w_bubble;
    logic         w_set_err;
    logic         w_count_inc;

    // Branch comes from the older instruction, so it overrides a jump.
    assign w_redirect          = branch_taken | jump;
    assign w_branch_misaligned = branch_taken & (branch_target[1:0] != 2'b00);
    assign w_target            = branch_taken ? {branch_target[31:2], 2'b00}
                                              : jump_target(if_id_pc4[31:28], jump_index);

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_fetch_err = ({1'b0, r_pc} >= IMEM_BYTES) || (r_pc[1:0] != 2'b00);
    assign w_is_halt   = (imem_instr == HALT_WORD);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_set_err    = 1'b0;
        w_count_inc  = 1'b0;

        case (r_state)
            BOOT: begin
                // Single settling cycle: PC holds, IF/ID untouched, stall ignored.
                w_state_next = RUN;
            end
            RUN: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                    w_bubble  = 1'b1;
                    w_set_err = w_branch_misaligned;
                end else if (stall) begin
                    // Hold everything.
                end else if (w_fetch_err) begin
                    w_bubble     = 1'b1;
                    w_set_err    = 1'b1;
                    w_state_next = HALT;
                end else begin
                    w_load      = 1'b1;
                    w_count_inc = 1'b1;
                    if (w_is_halt) begin
                        // PC parks on the halt word's own address.
                        w_state_next = HALT;
                    end else begin
                        w_pc_next = w_pc_plus4;
                    end
                end
            end
            HALT: begin
                w_bubble = 1'b1;
                // An older redirect overrides the speculative halt.
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_set_err    = w_branch_misaligned;
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = BOOT;
                w_bubble     = 1'b1;
            end
        endcase
    end

    // NOTE: all control/status registers are reset asynchronously; there is
    // no storage array here, so nothing is left without a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_count    <= 32'h0;
            r_halted   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            // Registered one cycle behind entry into HALT, dropping on exit.
            r_halted <= (r_state == HALT) && (w_state_next == HALT);
            if (w_set_err) begin
                r_addr_err <= 1'b1;
            end
            if (w_count_inc && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .bubble      (w_bubble),
        .load        (w_load),
        .instr       (imem_instr),
        .pc4         (w_pc_plus4),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign halted      = r_halted;
    assign addr_err    = r_addr_err;
    assign fetch_count = r_count;

endmodule
